demux_reg_bank: RTL and testbench

//  Write-side counterpart of the parameterized mux: decodes a binary select into a one-hot strobe and loads
//  one of P_WIDTH registers of P_DEPTH bits per clock. The register-file read muxes consume its packed output.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_reg_bank_decoder.sv | 25 ++
 rtl/demux_reg_bank.sv | 72 +++++++
 tb/tb_demux_reg_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demultiplexing register bank: default geometry and select helpers.
package demux_pkg;

    localparam int C_REG_COUNT = 16;
    localparam int C_REG_DEPTH = 16;

    // Select index width for a bank of `count` registers (never narrower than one bit).
    function automatic int sel_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic logic is_in_range(input int unsigned select, input int unsigned width);
        return select < width;
    endfunction

endpackage

// File: rtl/demux_reg_bank_decoder.sv
// Binary-to-one-hot decoder with enable; flags enabled selects that address no register.
module demux_reg_bank_decoder
    import demux_pkg::*;
#(
    parameter int P_WIDTH = C_REG_COUNT,
    localparam int SEL_W  = sel_width(P_WIDTH)
) (
    input  logic [SEL_W-1:0]   I_SELECT,
    input  logic               I_ENABLE,
    output logic [P_WIDTH-1:0] O_ONEHOT,
    output logic               O_OUT_OF_RANGE
);

    typedef logic [SEL_W-1:0] sel_t;

    // An out-of-range select simply matches no output bit.
    always_comb begin
        O_ONEHOT = '0;
        for (int i = 0; i < P_WIDTH; i++) begin
            O_ONEHOT[i] = I_ENABLE && (I_SELECT == sel_t'(i));
        end
        O_OUT_OF_RANGE = I_ENABLE && !is_in_range(32'(I_SELECT), P_WIDTH);
    end

endmodule

// File: rtl/demux_reg_bank.sv
// Write-side register bank: decodes a select into per-register load enables and tracks written entries.
// Optional macro DEMUX_REG_BANK_WRITE_THROUGH_EN forwards an accepted write's data to O_OUTPUT combinationally.
module demux_reg_bank
    import demux_pkg::*;
#(
    parameter int P_WIDTH = C_REG_COUNT,
    parameter int P_DEPTH = C_REG_DEPTH
) (
    input  logic                             I_CLK,
    input  logic                             I_RESET,
    input  logic                             I_WRITE_EN,
    input  logic                             I_CLEAR,
    input  logic [$clog2(P_WIDTH)-1:0]       I_SELECT,
    input  logic [P_DEPTH-1:0]               I_INPUT,
    output logic [P_WIDTH-1:0][P_DEPTH-1:0]  O_OUTPUT,
    output logic [P_WIDTH-1:0]               O_VALID,
    output logic [P_WIDTH-1:0]               O_WRITE_ONEHOT,
    output logic                             O_ERROR
);

    logic [P_WIDTH-1:0] load_onehot;
    logic               out_of_range;

    // Clear suppresses the decoder entirely, so a cleared write raises neither a strobe nor an error.
    demux_reg_bank_decoder #(
        .P_WIDTH        (P_WIDTH)
    ) u_decoder (
        .I_SELECT       (I_SELECT),
        .I_ENABLE       (I_WRITE_EN && !I_CLEAR),
        .O_ONEHOT       (load_onehot),
        .O_OUT_OF_RANGE (out_of_range)
    );

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
        if (I_RESET) begin
            O_WRITE_ONEHOT <= '0;
            O_ERROR        <= 1'b0;
        end else begin
            O_WRITE_ONEHOT <= load_onehot;
            O_ERROR        <= out_of_range;
        end
    end

    for (genvar g = 0; g < P_WIDTH; g++) begin : g_reg
        logic [P_DEPTH-1:0] data_q;
        logic               valid_q;

        // NOTE: the bank is flops, not RAM: reset and clear must zero every entry, so each one is reset.
        always_ff @(posedge I_CLK or posedge I_RESET) begin
            if (I_RESET) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (I_CLEAR) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (load_onehot[g]) begin
                data_q  <= I_INPUT;
                valid_q <= 1'b1;
            end
        end

        assign O_VALID[g] = valid_q;

`ifdef DEMUX_REG_BANK_WRITE_THROUGH_EN
        assign O_OUTPUT[g] = (load_onehot[g] && !I_RESET) ? I_INPUT : data_q;
`else
        assign O_OUTPUT[g] = data_q;
`endif
    end

endmodule

// File: tb/tb_demux_reg_bank.sv
// Self-checking bench: a 16-entry and a 12-entry bank share stimulus and are compared to array models.
module tb_demux_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  sel = '0;
    logic [15:0] din = '0;

    logic [15:0][15:0] out_a;
    logic [15:0]       valid_a, oh_a;
    logic              err_a;
    logic [11:0][15:0] out_b;
    logic [11:0]       valid_b, oh_b;
    logic              err_b;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [15:0] m_a [16];
    logic [15:0] m_b [12];
    logic [15:0] m_va, m_oha;
    logic [11:0] m_vb, m_ohb;
    logic        m_erra, m_errb;
    logic [15:0][15:0] ea;
    logic [11:0][15:0] eb;
    logic [15:0] wt_exp;

    demux_reg_bank #(.P_WIDTH(16), .P_DEPTH(16)) dut_a (
        .I_CLK(clk), .I_RESET(rst), .I_WRITE_EN(we), .I_CLEAR(clr), .I_SELECT(sel), .I_INPUT(din),
        .O_OUTPUT(out_a), .O_VALID(valid_a), .O_WRITE_ONEHOT(oh_a), .O_ERROR(err_a)
    );

    demux_reg_bank #(.P_WIDTH(12), .P_DEPTH(16)) dut_b (
        .I_CLK(clk), .I_RESET(rst), .I_WRITE_EN(we), .I_CLEAR(clr), .I_SELECT(sel), .I_INPUT(din),
        .O_OUTPUT(out_b), .O_VALID(valid_b), .O_WRITE_ONEHOT(oh_b), .O_ERROR(err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: registers as plain arrays, updated by the write rules at every edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_a[i] = '0;
            for (int i = 0; i < 12; i++) m_b[i] = '0;
            m_va = '0; m_vb = '0; m_oha = '0; m_ohb = '0; m_erra = 1'b0; m_errb = 1'b0;
        end else begin
            m_oha = '0; m_ohb = '0; m_erra = 1'b0; m_errb = 1'b0;
            if (clr) begin
                for (int i = 0; i < 16; i++) m_a[i] = '0;
                for (int i = 0; i < 12; i++) m_b[i] = '0;
                m_va = '0; m_vb = '0;
            end else if (we) begin
                m_a[int'(sel)] = din;
                m_va = m_va | (16'd1 << sel);
                m_oha = 16'd1 << sel;
                if (int'(sel) < 12) begin
                    m_b[int'(sel)] = din;
                    m_vb = m_vb | (12'd1 << sel);
                    m_ohb = 12'd1 << sel;
                end else begin
                    m_errb = 1'b1;
                end
            end
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) ea[i] = m_a[i];
        for (int i = 0; i < 12; i++) eb[i] = m_b[i];
`ifdef DEMUX_REG_BANK_WRITE_THROUGH_EN
        if (!rst && we && !clr) begin
            for (int i = 0; i < 16; i++) if (int'(sel) == i) ea[i] = din;
            for (int i = 0; i < 12; i++) if (int'(sel) == i) eb[i] = din;
        end
`endif
        check("out_a", out_a, ea);
        check("valid_a", valid_a, m_va);
        check("onehot_a", oh_a, m_oha);
        check("error_a", err_a, m_erra);
        check("out_b", out_b, eb);
        check("valid_b", valid_b, m_vb);
        check("onehot_b", oh_b, m_ohb);
        check("error_b", err_b, m_errb);
    end

    task automatic set_in(input logic w, input logic c, input logic [3:0] s, input logic [15:0] d);
        we = w; clr = c; sel = s; din = d;
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // reset at start
        next();
        next();
        check("init_out", out_a, '0);
        check("init_valid", valid_a, '0);
        rst = 1'b0;

        // single write, then idle
        set_in(1'b1, 1'b0, 4'd5, 16'hBEEF);
        next();
        check("t2_out5", out_a[5], 16'hBEEF);
        check("t2_valid", valid_a, 16'h0020);
        check("t2_onehot", oh_a, 16'h0020);
        check("t2_valid_b", valid_b, 12'h020);
        set_in(1'b0, 1'b0, 4'd0, 16'h0000);
        next();
        check("t2_idle_onehot", oh_a, 16'h0000);
        check("t2_idle_out5", out_a[5], 16'hBEEF);

        // sweep every select
        for (int s = 0; s < 16; s++) begin
            set_in(1'b1, 1'b0, 4'(s), 16'(s * 17));
            next();
        end
        check("t3_valid", valid_a, 16'hFFFF);
        check("t3_out15", out_a[15], 16'h00FF);
        check("t3_out3", out_a[3], 16'h0033);
        check("t3_valid_b", valid_b, 12'hFFF);
        check("t3_err_b", err_b, 1'b1);
        set_in(1'b0, 1'b0, 4'd0, 16'h0000);
        next();
        check("t3_err_b_drop", err_b, 1'b0);

        // out-of-range write on the 12-entry bank
        set_in(1'b1, 1'b0, 4'd13, 16'h1234);
        next();
        check("t4_err_b", err_b, 1'b1);
        check("t4_valid_b", valid_b, 12'hFFF);
        check("t4_out_b11", out_b[11], 16'h00BB);
        check("t4_onehot_b", oh_b, 12'h000);
        check("t4_out_a13", out_a[13], 16'h1234);
        check("t4_err_a", err_a, 1'b0);

        // reset between edges acts immediately and holds
        set_in(1'b0, 1'b0, 4'd0, 16'h0000);
        rst = 1'b1;
        #1;
        check("t1_out_now", out_a, '0);
        check("t1_valid_now", valid_a, '0);
        check("t1_onehot_now", oh_a, '0);
        check("t1_err_b_now", err_b, 1'b0);
        for (int k = 0; k < 3; k++) next();
        check("t1_out_held", out_b, '0);
        rst = 1'b0;

        // clear beats a simultaneous write
        set_in(1'b1, 1'b0, 4'd2, 16'h5555);
        next();
        check("t5_valid_pre", valid_a, 16'h0004);
        set_in(1'b1, 1'b1, 4'd3, 16'h7777);
        next();
        check("t5_out", out_a, '0);
        check("t5_valid", valid_a, '0);
        check("t5_onehot", oh_a, '0);
        check("t5_err", err_a, 1'b0);

        // write-through visibility, then reset mid-write
        set_in(1'b1, 1'b0, 4'd7, 16'h1111);
        next();
        set_in(1'b1, 1'b0, 4'd7, 16'hA5A5);
        #1;
`ifdef DEMUX_REG_BANK_WRITE_THROUGH_EN
        wt_exp = 16'hA5A5;
`else
        wt_exp = 16'h1111;
`endif
        check("t6_pre_edge", out_a[7], wt_exp);
        rst = 1'b1;
        #1;
        check("t6_rst_out", out_a, '0);
        next();
        set_in(1'b0, 1'b0, 4'd0, 16'h0000);
        rst = 1'b0;
        next();
        check("t6_lost_out7", out_a[7], 16'h0000);
        check("t6_lost_valid", valid_a, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            set_in(($urandom % 4) != 0, ($urandom % 16) == 0, 4'($urandom % 16), 16'($urandom));
            if (($urandom % 64) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            next();
        end

        set_in(1'b0, 1'b0, 4'd0, 16'h0000);
        next();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
